// File: rtl/sseg_pkg.sv
// Shared seven-segment constants and the BCD-to-segment lookup.
// Active-low patterns, bits 6..0 = segments g..a.
package sseg_pkg;

   localparam logic [6:0] SSEG_DIGIT [0:9] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };
   localparam logic [6:0] SSEG_DASH  = 7'h3F;
   localparam logic [6:0] SSEG_BLANK = 7'h7F;

   // Codes above 9 are not BCD and render as a dash.
   function automatic logic [6:0] bcd_to_sseg(input logic [3:0] bcd);
      logic [6:0] seg_s;
      if (bcd <= 4'd9) begin
         seg_s = SSEG_DIGIT[bcd];
      end else begin
         seg_s = SSEG_DASH;
      end
      return seg_s;
   endfunction

endpackage

// File: rtl/sseg_decoder.sv
// Combinational nibble-to-cathode decoder with blanking and decimal point.
// The dp is driven independently of blanking, so a blanked digit can still show it.
module sseg_decoder
   import sseg_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   input  logic       dp,
   output logic [7:0] sseg
);

   // Build the active-low cathode pattern for one digit.
   always_comb begin
      sseg = 8'hFF;
      if (blank) begin
         sseg[6:0] = SSEG_BLANK;
      end else begin
         sseg[6:0] = bcd_to_sseg(bcd);
      end
      sseg[7] = ~dp;
   end

endmodule

// File: rtl/sseg_mux4.sv
// Four-digit common-anode display scanner fed by the sseg4 BCD converter.
// Digits are captured only while the converter is idle; blanking and dp are used live.
module sseg_mux4
   import sseg_pkg::*;
#(
   parameter int REFRESH_BITS = 18
)(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [3:0] i_bcd3,
   input  logic [3:0] i_bcd2,
   input  logic [3:0] i_bcd1,
   input  logic [3:0] i_bcd0,
   input  logic       i_idle,
   input  logic       i_lz_blank,
   input  logic [3:0] i_dp,
   output logic [3:0] o_an,
   output logic [7:0] o_sseg
);

   logic [REFRESH_BITS-1:0] cnt_r;
   logic [3:0]              bcd_r [0:3];
   logic [1:0]              sel_s;
   logic [3:0]              zero_s;
   logic [3:0]              blank_s;
   logic [3:0]              digit_s;
   logic [3:0]              an_s;
   logic [7:0]              seg_s;

   assign sel_s = cnt_r[REFRESH_BITS-1 -: 2];

   // Leading-zero detection; an invalid code is never treated as zero.
   always_comb begin
      zero_s  = 4'b0000;
      blank_s = 4'b0000;
      for (int n = 0; n < 4; n++) begin
         zero_s[n] = (bcd_r[n] == 4'd0);
      end
      if (i_lz_blank) begin
         blank_s[3] = zero_s[3];
         blank_s[2] = zero_s[3] & zero_s[2];
         blank_s[1] = zero_s[3] & zero_s[2] & zero_s[1];
         blank_s[0] = 1'b0;
      end else begin
         blank_s = 4'b0000;
      end
   end

   // Select the scanned digit and its anode.
   always_comb begin
      digit_s = 4'd0;
      an_s    = 4'b1111;
      case (sel_s)
         2'd0:    begin digit_s = bcd_r[0]; an_s = 4'b1110; end
         2'd1:    begin digit_s = bcd_r[1]; an_s = 4'b1101; end
         2'd2:    begin digit_s = bcd_r[2]; an_s = 4'b1011; end
         2'd3:    begin digit_s = bcd_r[3]; an_s = 4'b0111; end
         default: begin digit_s = 4'd0;     an_s = 4'b1111; end
      endcase
   end

   sseg_decoder u_decoder (
      .bcd   (digit_s),
      .blank (blank_s[sel_s]),
      .dp    (i_dp[sel_s]),
      .sseg  (seg_s)
   );

   // Capture the converter digits while it reports idle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int n = 0; n < 4; n++) begin
            bcd_r[n] <= 4'd0;
         end
      end else if (i_idle) begin
         bcd_r[0] <= i_bcd0;
         bcd_r[1] <= i_bcd1;
         bcd_r[2] <= i_bcd2;
         bcd_r[3] <= i_bcd3;
      end else begin
         for (int n = 0; n < 4; n++) begin
            bcd_r[n] <= bcd_r[n];
         end
      end
   end

   // Free-running scan counter and registered display outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_r  <= '0;
         o_an   <= 4'b1111;
         o_sseg <= 8'hFF;
      end else begin
         cnt_r  <= cnt_r + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
         o_an   <= an_s;
         o_sseg <= seg_s;
      end
   end

endmodule

// File: tb/tb_sseg_mux4.sv
// Directed bench for sseg_mux4 with a 16-cycle scan period.
// Expected patterns are hand-computed per digit; a counter tracks the expected scan position.
module tb_sseg_mux4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] bcd3, bcd2, bcd1, bcd0;
   logic       idle;
   logic       lz_blank;
   logic [3:0] dp;
   logic [3:0] an;
   logic [7:0] sseg;

   int         vectors = 0;
   int         miscompares = 0;
   logic [3:0] cnt_m = 4'd0;
   logic [3:0] an_tab [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   always #5 clk = ~clk;

   sseg_mux4 #(.REFRESH_BITS(4)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_bcd3     (bcd3),
      .i_bcd2     (bcd2),
      .i_bcd1     (bcd1),
      .i_bcd0     (bcd0),
      .i_idle     (idle),
      .i_lz_blank (lz_blank),
      .i_dp       (dp),
      .o_an       (an),
      .o_sseg     (sseg)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [3:0] exp_an, input logic [7:0] exp_seg);
      vectors++;
      assert (an === exp_an) else begin
         miscompares++;
         $error("FAIL %s an: observed %b expected %b", tag, an, exp_an);
      end
      vectors++;
      assert (sseg === exp_seg) else begin
         miscompares++;
         $error("FAIL %s sseg: observed %h expected %h", tag, sseg, exp_seg);
      end
   endtask

   task automatic reset_cycle(input string tag);
      rst = 1'b1;
      step();
      cnt_m = 4'd0;
      check(tag, 4'b1111, 8'hFF);
   endtask

   // Run n cycles; e0..e3 are the expected patterns for digits 0..3.
   task automatic scan(input string tag, input int n,
                       input logic [7:0] e0, input logic [7:0] e1,
                       input logic [7:0] e2, input logic [7:0] e3);
      logic [7:0] e [0:3];
      logic [1:0] sel;
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      for (int i = 0; i < n; i++) begin
         sel = cnt_m[3:2];
         step();
         check(tag, an_tab[sel], e[sel]);
         cnt_m = cnt_m + 4'd1;
      end
   endtask

   task automatic capture(input logic [3:0] d3, input logic [3:0] d2,
                          input logic [3:0] d1, input logic [3:0] d0);
      idle = 1'b1;
      bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0;
      step();
      cnt_m = cnt_m + 4'd1;
      idle = 1'b0;
   endtask

   initial begin
      rst = 1'b1; idle = 1'b0; lz_blank = 1'b0; dp = 4'b0000;
      bcd3 = 4'd0; bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd0;

      reset_cycle("reset0");
      reset_cycle("reset1");
      rst = 1'b0;
      scan("post_reset", 1, 8'hC0, 8'hC0, 8'hC0, 8'hC0);

      // Capture 1,2,3,4; the first cycle still shows the old digit.
      idle = 1'b1;
      bcd3 = 4'd1; bcd2 = 4'd2; bcd1 = 4'd3; bcd0 = 4'd4;
      scan("capture_edge", 1, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
      idle = 1'b0;
      bcd3 = 4'd9; bcd2 = 4'd9; bcd1 = 4'd9; bcd0 = 4'd9;
      scan("capture_hold", 16, 8'h99, 8'hB0, 8'hA4, 8'hF9);
      scan("wrap40", 40, 8'h99, 8'hB0, 8'hA4, 8'hF9);

      // Leading-zero blanking.
      capture(4'd0, 4'd0, 4'd0, 4'd7);
      lz_blank = 1'b1;
      scan("lz_0007", 16, 8'hF8, 8'hFF, 8'hFF, 8'hFF);
      capture(4'd0, 4'd0, 4'd0, 4'd0);
      scan("lz_0000", 16, 8'hC0, 8'hFF, 8'hFF, 8'hFF);
      lz_blank = 1'b0;
      scan("nolz_0000", 16, 8'hC0, 8'hC0, 8'hC0, 8'hC0);
      capture(4'd0, 4'd0, 4'd2, 4'd0);
      lz_blank = 1'b1;
      scan("lz_0020", 16, 8'hC0, 8'hA4, 8'hFF, 8'hFF);

      // Decimal point and invalid BCD.
      lz_blank = 1'b0;
      dp = 4'b0100;
      capture(4'd5, 4'hB, 4'd8, 4'd6);
      scan("dp_dash", 16, 8'h82, 8'h80, 8'h3F, 8'h92);
      capture(4'd0, 4'hB, 4'd0, 4'd0);
      lz_blank = 1'b1;
      dp = 4'b1000;
      scan("lz_invalid_dp_blank", 16, 8'hC0, 8'hC0, 8'hBF, 8'h7F);

      // Reset while digit 2 is being scanned, also during a capture.
      while (cnt_m[3:2] != 2'd2) begin
         scan("to_digit2", 1, 8'hC0, 8'hC0, 8'hBF, 8'h7F);
      end
      idle = 1'b1;
      bcd3 = 4'd9; bcd2 = 4'd9; bcd1 = 4'd9; bcd0 = 4'd9;
      reset_cycle("mid_reset");
      idle = 1'b0;
      rst = 1'b0;
      lz_blank = 1'b0;
      dp = 4'b0000;
      scan("after_mid_reset", 16, 8'hC0, 8'hC0, 8'hC0, 8'hC0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sseg_mux4.md
# sseg_mux4

Time-multiplexed driver for a 4-digit common-anode seven-segment display. It sits directly downstream of the `sseg4` binary-to-BCD converter. It latches the four BCD digits whenever the converter reports idle, so the display never shows a conversion in progress. It then scans the digits onto shared active-low anode and cathode lines, with optional leading-zero blanking and per-digit decimal points.

## Interface
- `REFRESH_BITS`, 18: width of the free-running scan counter. The top 2 bits select the digit; the full scan period is 2^REFRESH_BITS cycles (2.62 ms at 100 MHz).
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_bcd3`, `i_bcd2`, `i_bcd1`, `i_bcd0`  in  4 each  BCD digits from the converter; `i_bcd3` is the most significant.
- `i_idle`  in  1  converter idle; digits are valid while high.
- `i_lz_blank`  in  1  enable leading-zero blanking.
- `i_dp`  in  4  decimal-point enables; bit n belongs to digit n, active-high.
- `o_an`  out  4  digit anodes, active-low, one-hot-low while scanning.
- `o_sseg`  out  8  cathodes, active-low. Bit 7 = dp; bits 6..0 = segments g..a.

## Operation
- **Capture register.** On each posedge with `i_idle`=1, latch all four digits. With `i_idle`=0, hold the previous values. `i_lz_blank` and `i_dp` are not latched; they are used live.
- **Scan counter.** `cnt[REFRESH_BITS-1:0]` increments every cycle and wraps from 2^REFRESH_BITS-1 to 0. `sel = cnt[REFRESH_BITS-1:REFRESH_BITS-2]` selects the digit:
  - 0 → `o_an`=1110
  - 1 → 1101
  - 2 → 1011
  - 3 → 0111
- **Segment decode** of the selected latched digit (dp bit = 1 before the dp merge):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Codes 10–15 (invalid BCD) show a dash, BF.
- **Leading-zero blanking** applies only when `i_lz_blank`=1. Blanked means 7-bit field = 7F.
  - Digit 3 is blanked if it is 0.
  - Digit 2 is blanked if digits 3 and 2 are both 0.
  - Digit 1 is blanked if digits 3, 2 and 1 are all 0.
  - Digit 0 is never blanked, so the value 0 shows a single "0".
  - An invalid digit counts as non-zero.
- **Decimal point.** `o_sseg[7] = ~i_dp[sel]`. The dp is shown even on a blanked digit.
- **Scan states.** The scan is the 4-state cycle `sel` 0→1→2→3→0, with no other states.

## Timing
- **Reset values** (the cycle after any posedge with `i_rst`=1):
  - `cnt`=0.
  - Latched digits = 0.
  - `o_an`=1111 (all off).
  - `o_sseg`=FF.
- **Reset mid-scan or mid-capture.** Same as above, taking effect at the next edge; the scan restarts from digit 0.
- **Registered outputs.** `o_an` and `o_sseg` are registered from the current `cnt`, latched digits, `i_lz_blank` and `i_dp`.
  - First posedge after `i_rst` falls: `o_an`=1110 and `o_sseg` shows digit 0.
- **Latency.**
  - Input digit sampled with `i_idle`=1 at edge k is latched at edge k.
  - It appears on `o_sseg` at edge k+1 if its digit is selected by `cnt` at that time.
  - The worst-case wait for display is one full scan period.
- **Simultaneous events.**
  - Capture and scan transition on the same edge are independent.
  - `i_rst` has priority over capture.
- **Non-overlap.** At most one anode is low in any cycle. `o_an` changes exactly every 2^(REFRESH_BITS-2) cycles.

## Structure
- Package `sseg_pkg` holds:
  - The segment constants: `SSEG_DIGIT[0:9]`, `SSEG_DASH`=7'h3F, `SSEG_BLANK`=7'h7F.
  - The function `bcd_to_sseg(logic [3:0]) → logic [6:0]`.
- Sub-module `sseg_decoder`, combinational, instantiated once:
  - Inputs: BCD nibble, blank flag, dp.
  - Output: 8-bit active-low pattern.
- `sseg_mux4` contains the capture register, counter, selection mux, blanking logic and output registers.

## Test plan
All directed tests use `REFRESH_BITS`=4 (4 cycles per digit, 16 per scan).
- **Reset.** Assert `i_rst` for 2 cycles, then release. During reset: `o_an`=1111 and `o_sseg`=FF. First edge after release: `o_an`=1110 and `o_sseg`=C0.
- **Capture.** Pulse `i_idle` with digits 1,2,3,4, then drop `i_idle` and change the inputs to 9,9,9,9. Over one full scan, digits 0..3 show 99, B0, A4, F9, with anodes 1110, 1101, 1011, 0111 for 4 cycles each.
- **Leading-zero blanking.** `i_lz_blank`=1 with digits 0,0,0,7, scanned in the order digit 0, 1, 2, 3 → F8, FF, FF, FF. With digits 0,0,0,0 → digit 0 = C0, others FF. With `i_lz_blank`=0 → all C0.
- **Dp and invalid BCD.** `i_dp`=0100 with digit 2 = 4'hB → on digit 2, `o_sseg`=3F (dash with dp on); other digits have bit 7 = 1.
- **Wrap and mid-scan reset.**
  - Run 40 cycles and confirm the `sel` sequence repeats every 16 cycles.
  - Assert `i_rst` while digit 2 is selected: the next edge gives 1111/FF; after release, the scan restarts at 1110.
- **Sweep with upstream.** Connect to `sseg4` and sweep `i_bin` 0..9999. At each idle, the captured digits match the decimal value of `i_bin`, and exactly one anode is low on every cycle after reset.
